// File: rtl/div_requester.sv
// -----------------------------------------------------------------------------
// div_requester
//
// Initiator side of the integer-divide valid/ready interface in the M-extension
// execute path. The block accepts one DIV/DIVU/REM/REMU operation at a time
// from the execute stage and registers its operands. It issues the request to
// the divider and captures the quotient or remainder. It then returns the
// tagged 32-bit result to writeback. flush_i cancels the operation without
// breaking the divider handshake: once the divider has accepted a request, its
// result is always consumed.
//
// Optional feature (compile-time macro DIV_REQ_BYPASS_EN):
//   When defined, divide-by-zero and signed overflow (0x80000000 / -1) are
//   resolved locally. The operation goes straight from IDLE to RESP without
//   being issued to the divider. When undefined, every operation goes to the
//   divider.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   op_valid_i/op_ready_o   operation handshake from execute
//   op_code_i               00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op_a_i/op_b_i           dividend / divisor
//   op_tag_i                destination-register tag
//   flush_i                 cancel pending / in-flight operation
//   div_in_valid_o/_ready_i request handshake to divider
//   div_a_o/div_b_o         registered operands to divider
//   div_signed_o            signed division (op_code[0] == 0)
//   div_out_valid_i/_ready_o result handshake from divider
//   div_c_i/div_r_i         divider quotient / remainder
//   res_valid_o/res_ready_i result handshake to writeback
//   res_data_o/res_tag_o    result data and tag
// -----------------------------------------------------------------------------
module div_requester #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  // Execute stage
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [1:0]       op_code_i,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic [TAG_W-1:0] op_tag_i,
  input  logic             flush_i,
  // Divider request
  output logic             div_in_valid_o,
  input  logic             div_in_ready_i,
  output logic [31:0]      div_a_o,
  output logic [31:0]      div_b_o,
  output logic             div_signed_o,
  // Divider response
  input  logic             div_out_valid_i,
  output logic             div_out_ready_o,
  input  logic [31:0]      div_c_i,
  input  logic [31:0]      div_r_i,
  // Writeback
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic [TAG_W-1:0] res_tag_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t             r_state;
  logic               r_op_ready;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic               r_signed;
  logic               r_sel_rem;   // op_code[1]: return the remainder
  logic [TAG_W-1:0]   r_tag;
  logic [31:0]        r_res;

`ifdef DIV_REQ_BYPASS_EN
  // Special-case detection on the incoming operands. It is used only at
  // acceptance, so the result lands in r_res one cycle later.
  logic        w_b_zero;
  logic        w_ovf;
  logic        w_bypass;
  logic [31:0] w_byp_res;

  assign w_b_zero = (op_b_i == 32'h0000_0000);
  assign w_ovf    = !op_code_i[0] && (op_a_i == 32'h8000_0000) &&
                    (op_b_i == 32'hFFFF_FFFF);
  assign w_bypass = w_b_zero || w_ovf;

  always_comb begin
    // NOTE: default assignment first so no path through this block leaves
    // w_byp_res unassigned, which would infer a latch.
    w_byp_res = 32'h0000_0000;
    if (w_b_zero) begin
      w_byp_res = op_code_i[1] ? op_a_i : 32'hFFFF_FFFF;
    end else if (w_ovf) begin
      w_byp_res = op_code_i[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end
`endif

  // Single FSM block. op_ready is kept as its own flop, not decoded from
  // r_state, so it can be low while reset is held even though the state is
  // IDLE. It rises with the first clock after reset deasserts.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the operand and result registers are reset too, because every
      // output, including the data buses, must read 0 out of reset.
      r_state    <= S_IDLE;
      r_op_ready <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_signed   <= 1'b0;
      r_sel_rem  <= 1'b0;
      r_tag      <= '0;
      r_res      <= '0;
    end else begin
      // NOTE: non-blocking assignments only. Every branch reads the
      // pre-edge values of the registers, the same way the flops behave.
      case (r_state)
        S_IDLE: begin
          r_op_ready <= 1'b1;
          if (op_valid_i && !flush_i) begin
            r_a        <= op_a_i;
            r_b        <= op_b_i;
            r_signed   <= !op_code_i[0];
            r_sel_rem  <= op_code_i[1];
            r_tag      <= op_tag_i;
            r_op_ready <= 1'b0;
`ifdef DIV_REQ_BYPASS_EN
            if (w_bypass) begin
              r_res   <= w_byp_res;
              r_state <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
`else
            r_state    <= S_ISSUE;
`endif
          end
        end

        S_ISSUE: begin
          // If the divider accepts in the same cycle as a flush, it now owns
          // a request. Its result must be drained before the next issue.
          if (div_in_ready_i) begin
            r_state <= flush_i ? S_DRAIN : S_WAIT;
          end else if (flush_i) begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b1;
          end
        end

        S_WAIT: begin
          if (div_out_valid_i) begin
            if (flush_i) begin
              // The result is consumed by this handshake and dropped.
              r_state    <= S_IDLE;
              r_op_ready <= 1'b1;
            end else begin
              r_res   <= r_sel_rem ? div_r_i : div_c_i;
              r_state <= S_RESP;
            end
          end else if (flush_i) begin
            r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (div_out_valid_i) begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b1;
          end
        end

        S_RESP: begin
          if (res_ready_i || flush_i) begin
            r_state    <= S_IDLE;
            r_op_ready <= 1'b1;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b1;
        end
      endcase
    end
  end

  // Handshake outputs are decoded from the state register only, so none of
  // them has a combinational path from an input.
  assign op_ready_o      = r_op_ready;
  assign div_in_valid_o  = (r_state == S_ISSUE);
  assign div_out_ready_o = (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign res_valid_o     = (r_state == S_RESP);

  assign div_a_o         = r_a;
  assign div_b_o         = r_b;
  assign div_signed_o    = r_signed;
  assign res_data_o      = r_res;
  assign res_tag_o       = r_tag;

endmodule

// File: tb/tb_div_requester.sv
// -----------------------------------------------------------------------------
// tb_div_requester
//
// Directed bench for div_requester. The table vectors run complete operations
// against a behavioural divider in this file, with programmable request-ready
// delay, divider latency and writeback back-pressure. The hand-written
// sequences cover flushes in each state, reset in WAIT, and (when
// DIV_REQ_BYPASS_EN is defined) the locally resolved special cases.
// -----------------------------------------------------------------------------
module tb_div_requester;

  localparam int TAG_W = 5;
  localparam logic [31:0] JUNK_C = 32'hDEAD_BEEF;
  localparam logic [31:0] JUNK_R = 32'hCAFE_F00D;

  logic             clock;
  logic             reset;
  logic             op_valid_i;
  logic             op_ready_o;
  logic [1:0]       op_code_i;
  logic [31:0]      op_a_i;
  logic [31:0]      op_b_i;
  logic [TAG_W-1:0] op_tag_i;
  logic             flush_i;
  logic             div_in_valid_o;
  logic             div_in_ready_i;
  logic [31:0]      div_a_o;
  logic [31:0]      div_b_o;
  logic             div_signed_o;
  logic             div_out_valid_i;
  logic             div_out_ready_o;
  logic [31:0]      div_c_i;
  logic [31:0]      div_r_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [31:0]      res_data_o;
  logic [TAG_W-1:0] res_tag_o;

  div_requester #(.TAG_W(TAG_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .op_valid_i      (op_valid_i),
    .op_ready_o      (op_ready_o),
    .op_code_i       (op_code_i),
    .op_a_i          (op_a_i),
    .op_b_i          (op_b_i),
    .op_tag_i        (op_tag_i),
    .flush_i         (flush_i),
    .div_in_valid_o  (div_in_valid_o),
    .div_in_ready_i  (div_in_ready_i),
    .div_a_o         (div_a_o),
    .div_b_o         (div_b_o),
    .div_signed_o    (div_signed_o),
    .div_out_valid_i (div_out_valid_i),
    .div_out_ready_o (div_out_ready_o),
    .div_c_i         (div_c_i),
    .div_r_i         (div_r_i),
    .res_valid_o     (res_valid_o),
    .res_ready_i     (res_ready_i),
    .res_data_o      (res_data_o),
    .res_tag_o       (res_tag_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string            name;
    logic [1:0]       opc;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    int               in_dly;   // cycles div_in_ready_i stays low
    int               lat;      // divider latency after acceptance
    int               rsp_dly;  // cycles res_ready_i stays low
    logic [31:0]      exp;      // hand-computed result
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural divider: quotient and remainder for the operands it received.
  task automatic div_model(input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, output logic [31:0] q,
                           output logic [31:0] r);
    if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // All drives and checks happen on the falling edge.
  task automatic start_op(input logic [1:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag);
    op_valid_i = 1'b1;
    op_code_i  = opc;
    op_a_i     = a;
    op_b_i     = b;
    op_tag_i   = tag;
    @(negedge clock);
    op_valid_i = 1'b0;
    op_a_i     = 32'h0;
    op_b_i     = 32'h0;
  endtask

  task automatic pulse_in_ready();
    div_in_ready_i = 1'b1;
    @(negedge clock);
    div_in_ready_i = 1'b0;
  endtask

  task automatic pulse_out_valid(input logic [31:0] q, input logic [31:0] r);
    div_out_valid_i = 1'b1;
    div_c_i         = q;
    div_r_i         = r;
    @(negedge clock);
    div_out_valid_i = 1'b0;
    div_c_i         = JUNK_C;
    div_r_i         = JUNK_R;
  endtask

  task automatic do_op(input vec_t v);
    logic        stable;
    logic [31:0] q;
    logic [31:0] r;
    check({v.name, " op_ready before"}, {31'b0, op_ready_o}, 32'd1);
    start_op(v.opc, v.a, v.b, v.tag);
    check({v.name, " div_in_valid"}, {31'b0, div_in_valid_o}, 32'd1);
    check({v.name, " div_a"}, div_a_o, v.a);
    check({v.name, " div_b"}, div_b_o, v.b);
    check({v.name, " div_signed"}, {31'b0, div_signed_o}, {31'b0, ~v.opc[0]});
    stable = 1'b1;
    for (int i = 0; i < v.in_dly; i++) begin
      @(negedge clock);
      if (div_in_valid_o !== 1'b1 || div_a_o !== v.a || div_b_o !== v.b ||
          op_ready_o !== 1'b0)
        stable = 1'b0;
    end
    check({v.name, " request held"}, {31'b0, stable}, 32'd1);
    pulse_in_ready();
    check({v.name, " div_in_valid drop"}, {31'b0, div_in_valid_o}, 32'd0);
    check({v.name, " div_out_ready"}, {31'b0, div_out_ready_o}, 32'd1);
    div_model(~v.opc[0], v.a, v.b, q, r);
    for (int i = 0; i < v.lat; i++) @(negedge clock);
    pulse_out_valid(q, r);
    check({v.name, " res_valid"}, {31'b0, res_valid_o}, 32'd1);
    check({v.name, " res_data"}, res_data_o, v.exp);
    check({v.name, " res_tag"}, {27'b0, res_tag_o}, {27'b0, v.tag});
    stable = 1'b1;
    for (int i = 0; i < v.rsp_dly; i++) begin
      @(negedge clock);
      if (res_valid_o !== 1'b1 || res_data_o !== v.exp ||
          res_tag_o !== v.tag || op_ready_o !== 1'b0)
        stable = 1'b0;
    end
    check({v.name, " result held"}, {31'b0, stable}, 32'd1);
    res_ready_i = 1'b1;
    @(negedge clock);
    res_ready_i = 1'b0;
    check({v.name, " res_valid after"}, {31'b0, res_valid_o}, 32'd0);
    check({v.name, " op_ready after"}, {31'b0, op_ready_o}, 32'd1);
  endtask

`ifdef DIV_REQ_BYPASS_EN
  task automatic bypass_op(input string name, input logic [1:0] opc,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    start_op(opc, a, b, 5'd9);
    check({name, " div_in_valid"}, {31'b0, div_in_valid_o}, 32'd0);
    check({name, " res_valid"}, {31'b0, res_valid_o}, 32'd1);
    check({name, " res_data"}, res_data_o, exp);
    res_ready_i = 1'b1;
    @(negedge clock);
    res_ready_i = 1'b0;
    check({name, " div_in_valid after"}, {31'b0, div_in_valid_o}, 32'd0);
    check({name, " op_ready after"}, {31'b0, op_ready_o}, 32'd1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"div100_7",   2'b00, 32'd100,         32'd7, 5'd3,  3, 40, 0, 32'd14};
    vecs[1] = '{"rem_m100_7", 2'b10, 32'hFFFF_FF9C,   32'd7, 5'd5,  0, 2,  0, 32'hFFFF_FFFE};
    vecs[2] = '{"divu_big_2", 2'b01, 32'hFFFF_FFFE,   32'd2, 5'd7,  1, 3,  5, 32'h7FFF_FFFF};
    vecs[3] = '{"remu_max10", 2'b11, 32'hFFFF_FFFF,   32'd10, 5'd31, 0, 0, 1, 32'd5};
    vecs[4] = '{"div_m100_7", 2'b00, 32'hFFFF_FF9C,   32'd7, 5'd1,  2, 1,  0, 32'hFFFF_FFF2};
    vecs[5] = '{"divu100_7",  2'b01, 32'd100,         32'd7, 5'd0,  0, 4,  2, 32'd14};
    vecs[6] = '{"rem100_7",   2'b10, 32'd100,         32'd7, 5'd16, 1, 1,  0, 32'd2};

    reset           = 1'b1;
    op_valid_i      = 1'b0;
    op_code_i       = 2'b00;
    op_a_i          = 32'h0;
    op_b_i          = 32'h0;
    op_tag_i        = '0;
    flush_i         = 1'b0;
    div_in_ready_i  = 1'b0;
    div_out_valid_i = 1'b0;
    div_c_i         = JUNK_C;
    div_r_i         = JUNK_R;
    res_ready_i     = 1'b0;
    repeat (3) @(negedge clock);
    check("reset op_ready", {31'b0, op_ready_o}, 32'd0);
    check("reset res_valid", {31'b0, res_valid_o}, 32'd0);
    check("reset div_in_valid", {31'b0, div_in_valid_o}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("post-reset op_ready", {31'b0, op_ready_o}, 32'd1);

    // An operation offered together with flush is not accepted.
    op_valid_i = 1'b1;
    flush_i    = 1'b1;
    @(negedge clock);
    op_valid_i = 1'b0;
    flush_i    = 1'b0;
    check("flush idle no issue", {31'b0, div_in_valid_o}, 32'd0);
    check("flush idle op_ready", {31'b0, op_ready_o}, 32'd1);

    for (int i = 0; i < 7; i++) do_op(vecs[i]);

    // Flush in WAIT: the divider result must still be consumed, then dropped.
    start_op(2'b00, 32'd20, 32'd4, 5'd2);
    pulse_in_ready();
    flush_i = 1'b1;
    @(negedge clock);
    flush_i = 1'b0;
    check("wflush out_ready", {31'b0, div_out_ready_o}, 32'd1);
    check("wflush op_ready", {31'b0, op_ready_o}, 32'd0);
    repeat (3) @(negedge clock);
    check("wflush still drain", {31'b0, div_out_ready_o}, 32'd1);
    pulse_out_valid(32'd5, 32'd0);
    check("wflush op_ready", {31'b0, op_ready_o}, 32'd1);
    check("wflush res_valid", {31'b0, res_valid_o}, 32'd0);
    check("wflush out_ready off", {31'b0, div_out_ready_o}, 32'd0);

    // Flush coinciding with the divider result in WAIT returns straight to IDLE.
    start_op(2'b00, 32'd20, 32'd4, 5'd2);
    pulse_in_ready();
    flush_i = 1'b1;
    pulse_out_valid(32'd5, 32'd0);
    flush_i = 1'b0;
    check("wcoinc res_valid", {31'b0, res_valid_o}, 32'd0);
    check("wcoinc op_ready", {31'b0, op_ready_o}, 32'd1);
    check("wcoinc out_ready", {31'b0, div_out_ready_o}, 32'd0);

    // Flush in ISSUE without ready drops the request.
    start_op(2'b01, 32'd30, 32'd3, 5'd4);
    flush_i = 1'b1;
    @(negedge clock);
    flush_i = 1'b0;
    check("iflush in_valid", {31'b0, div_in_valid_o}, 32'd0);
    check("iflush op_ready", {31'b0, op_ready_o}, 32'd1);
    check("iflush out_ready", {31'b0, div_out_ready_o}, 32'd0);

    // Flush in ISSUE while the divider accepts goes to DRAIN.
    start_op(2'b01, 32'd30, 32'd3, 5'd4);
    flush_i = 1'b1;
    pulse_in_ready();
    flush_i = 1'b0;
    check("iflush_rdy in_valid", {31'b0, div_in_valid_o}, 32'd0);
    check("iflush_rdy out_ready", {31'b0, div_out_ready_o}, 32'd1);
    check("iflush_rdy op_ready", {31'b0, op_ready_o}, 32'd0);
    @(negedge clock);
    pulse_out_valid(32'd10, 32'd0);
    check("iflush_rdy done", {31'b0, op_ready_o}, 32'd1);
    check("iflush_rdy res_valid", {31'b0, res_valid_o}, 32'd0);

    // Flush in RESP drops the pending result.
    start_op(2'b00, 32'd50, 32'd5, 5'd6);
    pulse_in_ready();
    pulse_out_valid(32'd10, 32'd0);
    check("rflush res before", {31'b0, res_valid_o}, 32'd1);
    flush_i = 1'b1;
    @(negedge clock);
    flush_i = 1'b0;
    check("rflush res_valid", {31'b0, res_valid_o}, 32'd0);
    check("rflush op_ready", {31'b0, op_ready_o}, 32'd1);

    // Reset in WAIT clears every output, including the data buses.
    start_op(2'b10, 32'd77, 32'd8, 5'd12);
    pulse_in_ready();
    reset = 1'b1;
    @(negedge clock);
    check("rst op_ready", {31'b0, op_ready_o}, 32'd0);
    check("rst div_in_valid", {31'b0, div_in_valid_o}, 32'd0);
    check("rst div_out_ready", {31'b0, div_out_ready_o}, 32'd0);
    check("rst res_valid", {31'b0, res_valid_o}, 32'd0);
    check("rst div_a", div_a_o, 32'd0);
    check("rst div_b", div_b_o, 32'd0);
    check("rst div_signed", {31'b0, div_signed_o}, 32'd0);
    check("rst res_data", res_data_o, 32'd0);
    check("rst res_tag", {27'b0, res_tag_o}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst release op_ready", {31'b0, op_ready_o}, 32'd1);
    do_op('{"div9_3", 2'b00, 32'd9, 32'd3, 5'd11, 0, 2, 0, 32'd3});

`ifdef DIV_REQ_BYPASS_EN
    bypass_op("byp div5_0",  2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
    bypass_op("byp rem5_0",  2'b10, 32'd5, 32'd0, 32'd5);
    bypass_op("byp divu5_0", 2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF);
    bypass_op("byp ovf_div", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    bypass_op("byp ovf_rem", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
